// File: rtl/reaction_game_timer_if.sv
// Command/status bundle for reaction_game_timer; the controller drives the commands
// (master) and the timer returns the digit chain and event pulses (slave).
interface reaction_game_timer_if #(
    parameter int unsigned STAGES  = 4,
    parameter int unsigned DIGIT_W = 4
);
    logic                        start;
    logic                        stop;
    logic                        clear;
    logic                        load;
    logic [STAGES*DIGIT_W-1:0]   load_val;
    logic                        down;
    logic [STAGES*DIGIT_W-1:0]   count;
    logic                        tick;
    logic                        carry;
    logic                        overflow;
    logic                        done;
    logic                        running;

    modport master (
        output start, stop, clear, load, load_val, down,
        input  count, tick, carry, overflow, done, running
    );

    modport slave (
        input  start, stop, clear, load, load_val, down,
        output count, tick, carry, overflow, done, running
    );
endinterface

// File: rtl/reaction_game_timer.sv
// Prescaled cascade of modulo-MOD digit counters with start/stop/resume, preload,
// up/down direction, wrap-or-saturate on up overflow and countdown expiry.
module reaction_game_timer #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned PRE_W    = 16,
    parameter int unsigned STAGES   = 4,
    parameter int unsigned DIGIT_W  = 4,
    parameter int unsigned MOD      = 10,
    parameter int unsigned SATURATE = 0
) (
    input logic                  clk,
    input logic                  reset,
    reaction_game_timer_if.slave bus
);
    localparam int unsigned          CNT_W   = STAGES * DIGIT_W;
    localparam logic [DIGIT_W-1:0]   DIG_MAX = DIGIT_W'(MOD - 1);
    localparam logic [PRE_W-1:0]     PRE_MAX = PRE_W'(PRESCALE - 1);

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("PRESCALE must be at least 2");
    end
    if (MOD < 2 || MOD > (1 << DIGIT_W)) begin : g_bad_mod
        $error("MOD must lie in 2 .. 2**DIGIT_W");
    end

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e             r_state;
    logic [PRE_W-1:0]   r_pre;
    logic [CNT_W-1:0]   r_count;
    logic               r_dir;
    logic               r_tick;
    logic               r_carry;
    logic               r_overflow;
    logic               r_done;
    logic               r_running;

    logic [CNT_W-1:0]   w_up_next;
    logic [CNT_W-1:0]   w_dn_next;
    logic [CNT_W-1:0]   w_clamped;
    logic               w_at_max;
    logic               w_at_zero;
    logic               w_wrap;
    logic               w_cmd_load;
    logic               w_cmd_stop;
    logic               w_cmd_start;

    // Only the highest-priority asserted command is considered; clear is handled first.
    always_comb begin
        w_cmd_load  = bus.load && !bus.clear;
        w_cmd_stop  = bus.stop && !bus.load && !bus.clear;
        w_cmd_start = bus.start && !bus.stop && !bus.load && !bus.clear;
        w_wrap      = (r_pre == PRE_MAX);
    end

    always_comb begin
        logic [DIGIT_W-1:0] w_digit;
        logic [DIGIT_W-1:0] w_ld_digit;
        logic               w_low_max;
        logic               w_low_zero;
        w_up_next  = r_count;
        w_dn_next  = r_count;
        w_clamped  = bus.load_val;
        w_low_max  = 1'b1;
        w_low_zero = 1'b1;
        w_digit    = '0;
        w_ld_digit = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            w_digit    = r_count[i*DIGIT_W +: DIGIT_W];
            w_ld_digit = bus.load_val[i*DIGIT_W +: DIGIT_W];
            if (w_low_max) begin
                w_up_next[i*DIGIT_W +: DIGIT_W] =
                    (w_digit == DIG_MAX) ? '0 : w_digit + DIGIT_W'(1);
            end
            if (w_low_zero) begin
                w_dn_next[i*DIGIT_W +: DIGIT_W] =
                    (w_digit == '0) ? DIG_MAX : w_digit - DIGIT_W'(1);
            end
            w_low_max  = w_low_max && (w_digit == DIG_MAX);
            w_low_zero = w_low_zero && (w_digit == '0);
            if (w_ld_digit > DIG_MAX) begin
                w_clamped[i*DIGIT_W +: DIGIT_W] = DIG_MAX;
            end
        end
        w_at_max  = w_low_max;
        w_at_zero = w_low_zero;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_pre      <= '0;
            r_count    <= '0;
            r_dir      <= 1'b0;
            r_tick     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
            if (bus.clear) begin
                r_state    <= StIdle;
                r_pre      <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_running  <= 1'b0;
            end else if (w_cmd_load && r_state != StRun) begin
                r_count <= w_clamped;
            end else if (w_cmd_stop && r_state == StRun) begin
                r_state   <= StHalt;
                r_running <= 1'b0;
            end else if (w_cmd_start && r_state == StIdle) begin
                r_dir     <= bus.down;
                r_pre     <= '0;
                r_state   <= StRun;
                r_running <= 1'b1;
            end else if (w_cmd_start && r_state == StHalt) begin
                r_state   <= StRun;
                r_running <= 1'b1;
            end else if (r_state == StRun) begin
                if (!w_wrap) begin
                    r_pre <= r_pre + PRE_W'(1);
                end else begin
                    r_pre  <= '0;
                    r_tick <= 1'b1;
                    if (!r_dir) begin
                        if (w_at_max) begin
                            r_carry    <= 1'b1;
                            r_overflow <= 1'b1;
                            if (SATURATE != 0) begin
                                r_state   <= StHalt;
                                r_running <= 1'b0;
                            end else begin
                                r_count <= '0;
                            end
                        end else begin
                            r_count <= w_up_next;
                        end
                    end else if (w_at_zero) begin
                        // Expiry parks at zero; no wrap to the all-max value.
                        r_carry   <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= StHalt;
                        r_running <= 1'b0;
                    end else begin
                        r_count <= w_dn_next;
                    end
                end
            end
        end
    end

    assign bus.count    = r_count;
    assign bus.tick     = r_tick;
    assign bus.carry    = r_carry;
    assign bus.overflow = r_overflow;
    assign bus.done     = r_done;
    assign bus.running  = r_running;

endmodule

// File: tb/tb_reaction_game_timer.sv
// Directed bench: a wrapping and a saturating timer (PRESCALE=3, two BCD digits) share one
// command stream; a per-cycle vector table plus a few multi-cycle corner sequences.
module tb_reaction_game_timer;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reaction_game_timer_if #(.STAGES(2), .DIGIT_W(4)) ifw ();
    reaction_game_timer_if #(.STAGES(2), .DIGIT_W(4)) ifs ();

    assign ifs.start    = ifw.start;
    assign ifs.stop     = ifw.stop;
    assign ifs.clear    = ifw.clear;
    assign ifs.load     = ifw.load;
    assign ifs.load_val = ifw.load_val;
    assign ifs.down     = ifw.down;

    reaction_game_timer #(
        .PRESCALE(3), .PRE_W(2), .STAGES(2), .DIGIT_W(4), .MOD(10), .SATURATE(0)
    ) u_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (ifw)
    );

    reaction_game_timer #(
        .PRESCALE(3), .PRE_W(2), .STAGES(2), .DIGIT_W(4), .MOD(10), .SATURATE(1)
    ) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs)
    );

    typedef struct {
        logic       st, sp, cl, ld, dn;
        logic [7:0] lv;
        logic [7:0] c;
        logic       r, t, o, d, ca;
        logic [7:0] sc;
        logic       sr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic sp, logic cl, logic ld, logic dn,
                                logic [7:0] lv, logic [7:0] c, logic r, logic t, logic o,
                                logic d, logic ca, logic [7:0] sc, logic sr);
        vec_t v;
        v.st = st; v.sp = sp; v.cl = cl; v.ld = ld; v.dn = dn; v.lv = lv;
        v.c = c; v.r = r; v.t = t; v.o = o; v.d = d; v.ca = ca; v.sc = sc; v.sr = sr;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        ifw.start = 1'b0; ifw.stop = 1'b0; ifw.clear = 1'b0;
        ifw.load = 1'b0; ifw.down = 1'b0; ifw.load_val = 8'h00;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) clk_step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        //          st sp cl ld dn lv       c     r  t  o  d  ca  sc    sr
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'hFA, 8'h99, 0, 0, 0, 0, 0, 8'h99, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h35, 8'h35, 0, 0, 0, 0, 0, 8'h35, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h3C, 8'h39, 0, 0, 0, 0, 0, 8'h39, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h39, 0, 0, 0, 0, 0, 8'h39, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h77, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h98, 8'h98, 0, 0, 0, 0, 0, 8'h98, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h98, 1, 0, 0, 0, 0, 8'h98, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'hFA, 8'h98, 1, 0, 0, 0, 0, 8'h98, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h98, 1, 0, 0, 0, 0, 8'h98, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h99, 1, 1, 0, 0, 0, 8'h99, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h99, 1, 0, 0, 0, 0, 8'h99, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h99, 1, 0, 0, 0, 0, 8'h99, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 1, 8'h99, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h99, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h99, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h99, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h99, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h99, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h01, 1, 1, 1, 0, 0, 8'h99, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));
        // Countdown from 03 to expiry, then a resume that expires again.
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h03, 8'h03, 0, 0, 0, 0, 0, 8'h03, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 8'h00, 8'h03, 1, 0, 0, 0, 0, 8'h03, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h03, 1, 0, 0, 0, 0, 8'h03, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h03, 1, 0, 0, 0, 0, 8'h03, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h02, 1, 1, 0, 0, 0, 8'h02, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h02, 1, 0, 0, 0, 0, 8'h02, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h02, 1, 0, 0, 0, 0, 8'h02, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h01, 1, 1, 0, 0, 0, 8'h01, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h01, 1, 0, 0, 0, 0, 8'h01, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h01, 1, 0, 0, 0, 0, 8'h01, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 1, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 1, 8'h00, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));

        zero_inputs();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("reset count",    32'(ifw.count),    32'h00);
        check("reset running",  32'(ifw.running),  32'h0);
        check("reset tick",     32'(ifw.tick),     32'h0);
        check("reset carry",    32'(ifw.carry),    32'h0);
        check("reset done",     32'(ifw.done),     32'h0);
        check("reset overflow", 32'(ifw.overflow), 32'h0);

        foreach (tbl[i]) begin
            ifw.start = tbl[i].st; ifw.stop = tbl[i].sp; ifw.clear = tbl[i].cl;
            ifw.load = tbl[i].ld; ifw.down = tbl[i].dn; ifw.load_val = tbl[i].lv;
            clk_step();
            zero_inputs();
            check($sformatf("row%0d count", i),     32'(ifw.count),    32'(tbl[i].c));
            check($sformatf("row%0d running", i),   32'(ifw.running),  32'(tbl[i].r));
            check($sformatf("row%0d tick", i),      32'(ifw.tick),     32'(tbl[i].t));
            check($sformatf("row%0d overflow", i),  32'(ifw.overflow), 32'(tbl[i].o));
            check($sformatf("row%0d done", i),      32'(ifw.done),     32'(tbl[i].d));
            check($sformatf("row%0d carry", i),     32'(ifw.carry),    32'(tbl[i].ca));
            check($sformatf("row%0d sat count", i), 32'(ifs.count),    32'(tbl[i].sc));
            check($sformatf("row%0d sat run", i),   32'(ifs.running),  32'(tbl[i].sr));
        end

        // stop+clear together on a wrap cycle: no tick, everything back to idle.
        ifw.load = 1'b1; ifw.load_val = 8'h99; clk_step(); zero_inputs();
        ifw.start = 1'b1; clk_step(); zero_inputs();
        idle(3);
        check("A wrap tick",     32'(ifw.tick),     32'h1);
        check("A wrap count",    32'(ifw.count),    32'h00);
        check("A wrap overflow", 32'(ifw.overflow), 32'h1);
        idle(2);
        ifw.stop = 1'b1; ifw.clear = 1'b1; clk_step(); zero_inputs();
        check("A clr tick",     32'(ifw.tick),     32'h0);
        check("A clr carry",    32'(ifw.carry),    32'h0);
        check("A clr count",    32'(ifw.count),    32'h00);
        check("A clr overflow", 32'(ifw.overflow), 32'h0);
        check("A clr running",  32'(ifw.running),  32'h0);

        // stop alone on a wrap cycle freezes the prescaler at its last value.
        ifw.load = 1'b1; ifw.load_val = 8'h42; clk_step(); zero_inputs();
        ifw.start = 1'b1; clk_step(); zero_inputs();
        idle(2);
        ifw.stop = 1'b1; clk_step(); zero_inputs();
        check("B stop tick",    32'(ifw.tick),    32'h0);
        check("B stop count",   32'(ifw.count),   32'h42);
        check("B stop running", 32'(ifw.running), 32'h0);
        ifw.start = 1'b1; clk_step(); zero_inputs();
        check("B resume tick",  32'(ifw.tick),  32'h0);
        check("B resume count", 32'(ifw.count), 32'h42);
        clk_step();
        check("B resume tick1",  32'(ifw.tick),  32'h1);
        check("B resume count1", 32'(ifw.count), 32'h43);
        ifw.clear = 1'b1; clk_step(); zero_inputs();

        // reset mid-run zeroes everything on the next cycle.
        ifw.load = 1'b1; ifw.load_val = 8'h99; clk_step(); zero_inputs();
        ifw.start = 1'b1; clk_step(); zero_inputs();
        idle(6);
        check("C pre count",    32'(ifw.count),    32'h01);
        check("C pre overflow", 32'(ifw.overflow), 32'h1);
        check("C sat overflow", 32'(ifs.overflow), 32'h1);
        reset = 1'b1; clk_step(); reset = 1'b0;
        check("C rst count",    32'(ifw.count),    32'h00);
        check("C rst running",  32'(ifw.running),  32'h0);
        check("C rst overflow", 32'(ifw.overflow), 32'h0);
        check("C rst tick",     32'(ifw.tick),     32'h0);
        check("C rst sat cnt",  32'(ifs.count),    32'h00);
        check("C rst sat ovf",  32'(ifs.overflow), 32'h0);

        // First tick arrives PRESCALE cycles after running rises.
        ifw.start = 1'b1; clk_step(); zero_inputs();
        check("D running", 32'(ifw.running), 32'h1);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            clk_step();
            if (ifw.tick && lat == 0) lat = k;
        end
        check("D tick latency", 32'(lat), 32'd3);
        check("D count", 32'(ifw.count), 32'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
